// File: rtl/rlbp_pkg.sv
// Shared defaults for the RLBP code buffer: code width, FIFO depth and the
// width of the FIFO fill-level count derived from the depth.
package rlbp_pkg;

    localparam int RLBP_CODE_W = 8;
    localparam int RLBP_DEPTH  = 8;
    localparam int RLBP_LVL_W  = $clog2(RLBP_DEPTH) + 1;

endpackage

// File: rtl/rlbp_sync_fifo.sv
// Synchronous show-ahead FIFO. The head entry is always visible on rdata.
// full/empty come from the fill level. A push into a full FIFO is accepted
// only when a pop happens in the same cycle. A pop on an empty FIFO is ignored.
module rlbp_sync_fifo
    import rlbp_pkg::*;
#(
    parameter int DEPTH  = RLBP_DEPTH,
    parameter int CODE_W = RLBP_CODE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [CODE_W-1:0]         push_data,
    input  logic                      pop,
    output logic                      accepted,
    output logic [CODE_W-1:0]         rdata,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign accepted = do_push;
    assign rdata    = mem[rd_ptr];

    // Storage write; entries are cleared on reset so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and level bookkeeping. Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rlbp_code_buffer.sv
// RLBP code buffer. Each group of CODE_W comparator samples is packed into one
// code, MSB first, and the code is pushed into a show-ahead FIFO. A frame-clear
// discards any partial code. A code dropped on a full FIFO raises a sticky
// overflow flag.
module rlbp_code_buffer
    import rlbp_pkg::*;
#(
    parameter int DEPTH  = RLBP_DEPTH,
    parameter int CODE_W = RLBP_CODE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmp_i,
    input  logic                      cmp_valid_i,
    input  logic                      clr_i,
    input  logic                      pop_i,
    output logic [CODE_W-1:0]         code_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      code_done_o,
    output logic                      overflow_o,
    input  logic                      ovf_clr_i
);

    localparam int                BC_W    = $clog2(CODE_W);
    localparam logic [BC_W-1:0]   BC_LAST = BC_W'(CODE_W - 1);

    logic [CODE_W-2:0] sh;
    logic [BC_W-1:0]   bcnt;
    logic              push_req;
    logic [CODE_W-1:0] push_data;
    logic              accepted;
    logic              strobe;

    // A frame-clear wins over a coincident strobe, so that strobe adds no bit.
    assign strobe    = cmp_valid_i && !clr_i;
    assign push_req  = strobe && (bcnt == BC_LAST);
    assign push_data = {sh, cmp_i};

    // Assembler: shift in one bit per strobe; restart on completion or frame-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            bcnt <= '0;
        end else if (clr_i || push_req) begin
            sh   <= '0;
            bcnt <= '0;
        end else if (cmp_valid_i) begin
            sh   <= {sh[CODE_W-3:0], cmp_i};
            bcnt <= bcnt + BC_W'(1);
        end
    end

    rlbp_sync_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_data),
        .pop       (pop_i),
        .accepted  (accepted),
        .rdata     (code_o),
        .empty     (empty_o),
        .full      (full_o),
        .level     (level_o)
    );

    // Completion pulse appears together with the new FIFO contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) code_done_o <= 1'b0;
        else        code_done_o <= accepted;
    end

    // Sticky overflow. A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    overflow_o <= 1'b0;
        else if (push_req && !accepted) overflow_o <= 1'b1;
        else if (ovf_clr_i)             overflow_o <= 1'b0;
    end

endmodule

// File: tb/tb_rlbp_code_buffer.sv
// Bench for rlbp_code_buffer. Directed steps followed by randomized traffic.
// Every cycle is compared against a queue-based reference model.
module tb_rlbp_code_buffer;

    localparam int DEPTH  = 8;
    localparam int CODE_W = 8;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmp = 1'b0, cmp_valid = 1'b0, clr = 1'b0, pop = 1'b0, ovf_clr = 1'b0;
    logic [CODE_W-1:0] code;
    logic              empty, full, code_done, overflow;
    logic [LVL_W-1:0]  level;

    int errors = 0;
    int checks = 0;

    // Reference model state: queued codes, partial code value/bit count, flags.
    int mq[$];
    int m_val = 0;
    int m_n   = 0;
    bit m_done = 0;
    bit m_ovf  = 0;

    always #5 clk = ~clk;

    rlbp_code_buffer #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmp_i       (cmp),
        .cmp_valid_i (cmp_valid),
        .clr_i       (clr),
        .pop_i       (pop),
        .code_o      (code),
        .empty_o     (empty),
        .full_o      (full),
        .level_o     (level),
        .code_done_o (code_done),
        .overflow_o  (overflow),
        .ovf_clr_i   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_val = 0; m_n = 0; m_done = 0; m_ovf = 0;
    endtask

    // One clock of the behavioural model, evaluated on the inputs of that clock.
    task automatic model_step(input bit c, input bit v, input bit cl, input bit p, input bit oc);
        bit complete = 0;
        bit drop = 0;
        int cw = 0;
        int sz = mq.size();
        bit popped = p && (sz > 0);
        if (cl) begin
            m_val = 0; m_n = 0;
        end else if (v) begin
            m_val = ((m_val << 1) | int'(c)) & 'hFF;
            m_n++;
            if (m_n == CODE_W) begin
                complete = 1; cw = m_val; m_val = 0; m_n = 0;
            end
        end
        if (popped) void'(mq.pop_front());
        m_done = 0;
        if (complete) begin
            if (sz < DEPTH || popped) begin
                mq.push_back(cw);
                m_done = 1;
            end else begin
                drop = 1;
            end
        end
        if (drop)    m_ovf = 1;
        else if (oc) m_ovf = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".empty"}, empty, mq.size() == 0);
        chk({tag, ".full"}, full, mq.size() == DEPTH);
        chk({tag, ".level"}, level, mq.size());
        chk({tag, ".done"}, code_done, m_done);
        chk({tag, ".ovf"}, overflow, m_ovf);
        if (mq.size() > 0) chk({tag, ".code"}, code, mq[0]);
    endtask

    // Called at posedge+1: drive inputs, clock once, then compare against the model.
    task automatic cycle(input bit c, input bit v, input bit cl, input bit p, input bit oc,
                         input string tag = "cyc");
        cmp = c; cmp_valid = v; clr = cl; pop = p; ovf_clr = oc;
        @(posedge clk);
        #1;
        model_step(c, v, cl, p, oc);
        chk_all(tag);
    endtask

    task automatic send_code(input int b, input bit pop_last, input bit oc_last = 0);
        for (int i = CODE_W - 1; i >= 0; i--)
            cycle(b[i], 1'b1, 1'b0, (i == 0) ? pop_last : 1'b0, (i == 0) ? oc_last : 1'b0, "send");
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && mq.size() > 0; i++) cycle(0, 0, 0, 1, 0, "drain");
        chk("drain_empty", empty, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".code"}, code, 0);
        chk({tag, ".empty"}, empty, 1);
        chk({tag, ".full"}, full, 0);
        chk({tag, ".level"}, level, 0);
        chk({tag, ".done"}, code_done, 0);
        chk({tag, ".ovf"}, overflow, 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic code 1,0,1,1,0,0,1,0 -> B2
        send_code('hB2, 0);
        chk("basic_code", code, 'hB2);
        chk("basic_done", code_done, 1);
        cycle(0, 0, 0, 0, 0, "basic_idle");
        chk("basic_done_once", code_done, 0);
        drain();

        // Pop while empty has no effect
        cycle(0, 0, 0, 1, 0, "pop_empty");
        cycle(0, 0, 0, 1, 0, "pop_empty");

        // Frame clear: 5 strobes, clear with a coincident strobe, then 8 ones
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, "partial");
        cycle(1, 1, 1, 0, 0, "clear");
        send_code('hFF, 0);
        chk("clr_level", level, 1);
        chk("clr_code", code, 'hFF);
        drain();

        // Fill and overflow: 9 codes, no pops
        for (int k = 1; k <= 9; k++) send_code(k, 0);
        chk("fill_full", full, 1);
        chk("fill_level", level, DEPTH);
        chk("fill_ovf", overflow, 1);
        // ovf_clr coincident with clear-then-nothing: clears
        cycle(0, 0, 0, 0, 1, "ovf_clr");
        chk("ovf_cleared", overflow, 0);
        // Drop in the same cycle as ovf_clr: set wins
        send_code('h77, 0, 1);
        chk("ovf_set_wins", overflow, 1);
        cycle(0, 0, 0, 0, 1, "ovf_clr2");
        // Full with simultaneous push and pop
        send_code('hAA, 1);
        chk("fullpp_level", level, DEPTH);
        chk("fullpp_ovf", overflow, 0);
        chk("fullpp_done", code_done, 1);
        drain();

        // Push and pop together on an empty FIFO: pop ignored
        send_code('h3C, 1);
        chk("empty_pp_level", level, 1);
        drain();

        // Interleaved wrap-around traffic
        for (int k = 0; k < 20; k++) begin
            send_code((k * 37 + 5) & 'hFF, k[0]);
            if (k % 3 == 0) cycle(0, 0, 0, 1, 0, "wrap_pop");
        end
        drain();
        cycle(0, 0, 0, 1, 0, "wrap_pop_empty");

        // Async reset during the 4th strobe with 3 entries queued
        send_code('h11, 0);
        send_code('h22, 0);
        send_code('h33, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, "pre_rst");
        cmp = 1'b1; cmp_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("async_rst");
        model_reset();
        cmp_valid = 1'b0; cmp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst");
        send_code('h5C, 0);
        chk("post_rst_code", code, 'h5C);
        chk("post_rst_level", level, 1);

        // Randomized traffic: slow pops first to provoke overflow, then fast pops
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0, "rand_slow");
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, "rand_fast");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
